// File: rtl/lcd_pkg.sv
// lcd_pkg: shared FSM encoding, LCD command bytes and sequence lengths
//   for the HD44780 display sequencer and its character buffer.
package lcd_pkg;

    localparam logic [2:0] ST_PWR_WAIT = 3'd0;
    localparam logic [2:0] ST_ISSUE    = 3'd1;
    localparam logic [2:0] ST_ACK_HOLD = 3'd2;
    localparam logic [2:0] ST_ACK_WAIT = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_IDLE     = 3'd5;

    typedef enum logic {SEQ_INIT, SEQ_REFRESH} seq_t;

    localparam logic [7:0] CMD_FUNC_SET = 8'h38;
    localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
    localparam logic [7:0] CMD_ENTRY    = 8'h06;
    localparam logic [7:0] CMD_CLEAR    = 8'h01;
    localparam logic [7:0] CMD_LINE1    = 8'h80;
    localparam logic [7:0] CMD_LINE2    = 8'hC0;
    localparam logic [7:0] CHAR_SPACE   = 8'h20;

    localparam int INIT_LEN    = 4;
    localparam int REFRESH_LEN = 34;

    function automatic logic [7:0] init_cmd(input logic [5:0] step);
        return step == 6'd0 ? CMD_FUNC_SET :
               step == 6'd1 ? CMD_DISP_ON  :
               step == 6'd2 ? CMD_ENTRY    : CMD_CLEAR;
    endfunction

endpackage

// File: rtl/lcd_char_buffer.sv
// lcd_char_buffer: 32x8 character store, one write port, one combinational read port.
//   clock, reset   : system clock, synchronous active-high reset (all entries -> space)
//   we/wr_addr/wr_data : write port, one write per cycle
//   rd_addr/rd_data    : asynchronous read port
module lcd_char_buffer
    import lcd_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       we,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem [32];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mem[i] <= CHAR_SPACE;
        end else if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lcd_display_sequencer.sv
// lcd_display_sequencer: runs HD44780 power-up init, then refreshes a 2x16 buffer to the LCD controller.
//   clock, reset        : system clock, synchronous active-high reset
//   buf_we/addr/data    : host character writes (0-15 line 1, 16-31 line 2)
//   refresh_req         : one-cycle refresh request (merged into one pending request while busy)
//   busy, init_done     : status
//   ctl_data/rs/start   : transfer to the LCD controller, ctl_done : controller completion flag
//   Optional macro LCD_AUTO_REFRESH_EN: refresh automatically from IDLE after any buffer write.
module lcd_display_sequencer
    import lcd_pkg::*;
#(
    parameter int POWERON_CYCLES = 750000,
    parameter int CMD_DELAY      = 2000,
    parameter int CLEAR_DELAY    = 82000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_data,
    input  logic       refresh_req,
    output logic       busy,
    output logic       init_done,
    output logic [7:0] ctl_data,
    output logic       ctl_rs,
    output logic       ctl_start,
    input  logic       ctl_done
);

    localparam int MAX_A  = POWERON_CYCLES > CLEAR_DELAY ? POWERON_CYCLES : CLEAR_DELAY;
    localparam int MAX_CY = MAX_A > CMD_DELAY ? MAX_A : CMD_DELAY;
    localparam int CW     = $clog2(MAX_CY + 1);

    logic [2:0]    state;
    seq_t          seq;
    logic [5:0]    step;
    logic [CW-1:0] cnt;
    logic [CW-1:0] gap_last;
    logic          pending;
    logic          auto_req;
    logic          start_refresh;
    logic          last_step;
    logic          step_rs;
    logic [7:0]    step_data;
    logic [4:0]    rd_addr;
    logic [7:0]    rd_data;

    lcd_char_buffer u_buf (
        .clock   (clock),
        .reset   (reset),
        .we      (buf_we),
        .wr_addr (buf_addr),
        .wr_data (buf_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Refresh steps 1-16 read buf[0..15], steps 18-33 read buf[16..31].
    always_comb begin
        rd_addr   = 5'(step - (step > 6'd17 ? 6'd2 : 6'd1));
        step_rs   = seq == SEQ_REFRESH && step != 6'd0 && step != 6'd17;
        step_data = seq == SEQ_INIT ? init_cmd(step) :
                    step == 6'd0    ? CMD_LINE1      :
                    step == 6'd17   ? CMD_LINE2      : rd_data;
        last_step = step == (seq == SEQ_INIT ? 6'(INIT_LEN - 1) : 6'(REFRESH_LEN - 1));
        // The held transfer byte tells whether the gap follows a clear command.
        gap_last  = !ctl_rs && ctl_data == CMD_CLEAR ? CW'(CLEAR_DELAY - 1) : CW'(CMD_DELAY - 1);
    end

    assign busy          = state != ST_IDLE;
    assign start_refresh = state == ST_IDLE && (pending || refresh_req || auto_req);

`ifdef LCD_AUTO_REFRESH_EN
    logic dirty;

    always_ff @(posedge clock) begin
        if (reset) dirty <= 1'b0;
        else       dirty <= start_refresh ? 1'b0 : dirty | buf_we;
    end

    assign auto_req = dirty;
`else
    assign auto_req = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ST_PWR_WAIT;
            seq       <= SEQ_INIT;
            step      <= 6'd0;
            cnt       <= '0;
            pending   <= 1'b0;
            init_done <= 1'b0;
            ctl_start <= 1'b0;
            ctl_data  <= 8'h00;
            ctl_rs    <= 1'b0;
        end else begin
            ctl_start <= 1'b0;
            if (refresh_req && state != ST_IDLE) pending <= 1'b1;
            case (state)
                ST_PWR_WAIT: begin
                    if (cnt == CW'(POWERON_CYCLES - 1)) begin
                        cnt   <= '0;
                        seq   <= SEQ_INIT;
                        step  <= 6'd0;
                        state <= ST_ISSUE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ISSUE: begin
                    ctl_data  <= step_data;
                    ctl_rs    <= step_rs;
                    ctl_start <= 1'b1;
                    state     <= ST_ACK_HOLD;
                end
                // ctl_done is still high from the previous transfer for a couple of cycles.
                ST_ACK_HOLD: begin
                    if (cnt == CW'(1)) begin
                        cnt   <= '0;
                        state <= ST_ACK_WAIT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_ACK_WAIT: if (ctl_done) state <= ST_GAP;
                ST_GAP: begin
                    if (cnt == gap_last) begin
                        cnt <= '0;
                        if (last_step) begin
                            state <= ST_IDLE;
                            if (seq == SEQ_INIT) init_done <= 1'b1;
                        end else begin
                            step  <= step + 6'd1;
                            state <= ST_ISSUE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (start_refresh) begin
                        seq     <= SEQ_REFRESH;
                        step    <= 6'd0;
                        pending <= 1'b0;
                        state   <= ST_ISSUE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_display_sequencer.sv
// tb_lcd_display_sequencer: randomized self-checking bench with an LCD controller model and buffer model.
module tb_lcd_display_sequencer;

    localparam int PWR = 20;
    localparam int CMD = 4;
    localparam int CLR = 10;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       buf_we = 1'b0;
    logic [4:0] buf_addr = 5'd0;
    logic [7:0] buf_data = 8'd0;
    logic       refresh_req = 1'b0;
    logic       ctl_done = 1'b1;
    logic       busy, init_done, ctl_rs, ctl_start;
    logic [7:0] ctl_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dcnt = 0;
    int rel_cyc = 0;

    logic [7:0] shadow [32];
    logic [7:0] init_seq [4];
    logic [7:0] got_d [$];
    logic       got_rs [$];
    int         got_t [$];

    lcd_display_sequencer #(
        .POWERON_CYCLES (PWR),
        .CMD_DELAY      (CMD),
        .CLEAR_DELAY    (CLR)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .buf_we      (buf_we),
        .buf_addr    (buf_addr),
        .buf_data    (buf_data),
        .refresh_req (refresh_req),
        .busy        (busy),
        .init_done   (init_done),
        .ctl_data    (ctl_data),
        .ctl_rs      (ctl_rs),
        .ctl_start   (ctl_start),
        .ctl_done    (ctl_done)
    );

    always #5 clock = ~clock;

    // LCD controller model: done falls the cycle after start, rises 16 cycles after that.
    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (ctl_start) begin
            ctl_done <= 1'b0;
            dcnt     <= 16;
        end else if (dcnt != 0) begin
            dcnt <= dcnt - 1;
            if (dcnt == 1) ctl_done <= 1'b1;
        end
    end

    always @(negedge clock) begin
        if (ctl_start) begin
            got_d.push_back(ctl_data);
            got_rs.push_back(ctl_rs);
            got_t.push_back(cyc);
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        buf_we = 1'b1;
        buf_addr = a;
        buf_data = d;
        tick(1);
        buf_we = 1'b0;
    endtask

    task automatic pulse_req();
        refresh_req = 1'b1;
        tick(1);
        refresh_req = 1'b0;
    endtask

    task automatic wait_starts(input int n, input int budget, input string tag);
        int b = budget;
        while (got_d.size() < n && b > 0) begin
            tick(1);
            b--;
        end
        checks++;
        if (got_d.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d transfers, want %0d", tag, got_d.size(), n);
        end
    endtask

    task automatic wait_idle(input int budget, input string tag, output int t);
        int b = budget;
        while (busy && b > 0) begin
            tick(1);
            b--;
        end
        t = cyc;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b want 0 within %0d cycles", tag, busy, budget);
        end
    endtask

    // Expected refresh: line-address command then the 16 characters of that line, for both lines.
    task automatic check_refresh(input int base, input string tag);
        logic [7:0] ed [$];
        logic       er [$];
        for (int l = 0; l < 2; l++) begin
            ed.push_back(l == 0 ? 8'h80 : 8'hC0);
            er.push_back(1'b0);
            for (int c = 0; c < 16; c++) begin
                ed.push_back(shadow[l * 16 + c]);
                er.push_back(1'b1);
            end
        end
        for (int k = 0; k < ed.size(); k++) begin
            checks++;
            if (base + k >= got_d.size()) begin
                errors++;
                $display("FAIL %s step %0d: transfer missing, want %h/%b", tag, k, ed[k], er[k]);
            end else if (got_d[base + k] !== ed[k] || got_rs[base + k] !== er[k]) begin
                errors++;
                $display("FAIL %s step %0d: got %h/%b want %h/%b", tag, k,
                         got_d[base + k], got_rs[base + k], ed[k], er[k]);
            end
        end
    endtask

    task automatic check_init(input string tag);
        int base = got_d.size();
        int b = 100;
        wait_starts(base + 4, 400, tag);
        if (got_d.size() < base + 4) return;
        checks++;
        if (got_t[base] - rel_cyc !== PWR + 1) begin
            errors++;
            $display("FAIL %s first start: got %0d cycles after reset, want %0d",
                     tag, got_t[base] - rel_cyc, PWR + 1);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got_d[base + i] !== init_seq[i] || got_rs[base + i] !== 1'b0) begin
                errors++;
                $display("FAIL %s cmd %0d: got %h/%b want %h/0", tag, i,
                         got_d[base + i], got_rs[base + i], init_seq[i]);
            end
        end
        // start -> done (17) -> seen (1) -> gap -> issue (1)
        for (int i = 1; i < 4; i++) begin
            checks++;
            if (got_t[base + i] - got_t[base + i - 1] !== 19 + CMD) begin
                errors++;
                $display("FAIL %s interval %0d: got %0d want %0d", tag, i,
                         got_t[base + i] - got_t[base + i - 1], 19 + CMD);
            end
        end
        while (!init_done && b > 0) begin
            checks++;
            if (busy !== 1'b1) begin
                errors++;
                $display("FAIL %s busy during init: got %b want 1", tag, busy);
            end
            tick(1);
            b--;
        end
        checks++;
        if (cyc - got_t[base + 3] !== 18 + CLR) begin
            errors++;
            $display("FAIL %s init_done rise: got %0d cycles after clear start, want %0d",
                     tag, cyc - got_t[base + 3], 18 + CLR);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy after init: got %b want 0", tag, busy);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        reset = 1'b1;
        tick(3);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL reset busy: got %b want 1", busy); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL reset init_done: got %b want 0", init_done); end
        checks++;
        if (ctl_start !== 1'b0) begin errors++; $display("FAIL reset ctl_start: got %b want 0", ctl_start); end
        checks++;
        if (ctl_data !== 8'h00) begin errors++; $display("FAIL reset ctl_data: got %h want 00", ctl_data); end
        checks++;
        if (ctl_rs !== 1'b0) begin errors++; $display("FAIL reset ctl_rs: got %b want 0", ctl_rs); end
        reset = 1'b0;
        rel_cyc = cyc;
    endtask

    task automatic test_init();
        check_init("init");
    endtask

    task automatic test_hello();
        logic [7:0] msg [5];
        int base, t;
        msg = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
        for (int i = 0; i < 5; i++) begin
            wr(5'(i), msg[i]);
            shadow[i] = msg[i];
        end
        base = got_d.size();
        pulse_req();
        wait_starts(base + 34, 34 * 40, "hello");
        check_refresh(base, "hello");
        wait_idle(200, "hello idle", t);
        if (got_d.size() >= base + 34) begin
            checks++;
            if (t - got_t[base + 33] !== 18 + CMD) begin
                errors++;
                $display("FAIL hello busy fall: got %0d cycles after last start, want %0d",
                         t - got_t[base + 33], 18 + CMD);
            end
        end
        tick(60);
        checks++;
        if (got_d.size() !== base + 34) begin
            errors++;
            $display("FAIL hello count: got %0d transfers want %0d", got_d.size() - base, 34);
        end
    endtask

    task automatic test_random_fill();
        int base, t;
        repeat (24) begin
            logic [4:0] a;
            logic [7:0] d;
            a = 5'($urandom_range(31));
            d = 8'($urandom_range(255));
            wr(a, d);
            shadow[a] = d;
            if ($urandom_range(1) == 1) tick($urandom_range(1, 3));
        end
        base = got_d.size();
        pulse_req();
        wait_starts(base + 34, 34 * 40, "random");
        check_refresh(base, "random");
        wait_idle(200, "random idle", t);
    endtask

    task automatic test_back_to_back();
        int base, t;
        base = got_d.size();
        pulse_req();
        wait_starts(base + 3, 200, "merge start");
        repeat (3) begin
            tick($urandom_range(1, 30));
            pulse_req();
        end
        wait_starts(base + 68, 68 * 40, "merge");
        check_refresh(base, "merge first");
        check_refresh(base + 34, "merge second");
        wait_idle(200, "merge idle", t);
        tick(150);
        checks++;
        if (got_d.size() !== base + 68) begin
            errors++;
            $display("FAIL merge count: got %0d transfers want %0d", got_d.size() - base, 68);
        end
    endtask

    task automatic test_mid_write();
        int base, t;
        logic [7:0] new0;
        base = got_d.size();
        pulse_req();
        wait_starts(base + 5, 400, "midwrite start");
        new0 = ~shadow[0];
        wr(5'd31, 8'h41);
        wr(5'd0, new0);
        shadow[31] = 8'h41;
        wait_starts(base + 34, 34 * 40, "midwrite");
        check_refresh(base, "midwrite");
        shadow[0] = new0;
        wait_idle(200, "midwrite idle", t);
        base = got_d.size();
        pulse_req();
        wait_starts(base + 34, 34 * 40, "midwrite next");
        check_refresh(base, "midwrite next");
        wait_idle(200, "midwrite next idle", t);
    endtask

    task automatic test_reset_mid();
        int base, t;
        base = got_d.size();
        pulse_req();
        wait_starts(base + 1, 200, "abort start");
        tick(6);
        reset = 1'b1;
        tick(1);
        checks++;
        if (ctl_start !== 1'b0) begin errors++; $display("FAIL abort ctl_start: got %b want 0", ctl_start); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort busy: got %b want 1", busy); end
        checks++;
        if (init_done !== 1'b0) begin errors++; $display("FAIL abort init_done: got %b want 0", init_done); end
        tick(1);
        reset = 1'b0;
        rel_cyc = cyc;
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        check_init("abort init");
        base = got_d.size();
        pulse_req();
        wait_starts(base + 34, 34 * 40, "abort refresh");
        check_refresh(base, "abort refresh");
        wait_idle(200, "abort idle", t);
    endtask

    task automatic test_auto_refresh();
        int base;
        logic [4:0] a;
        logic [7:0] d;
        tick(5);
        base = got_d.size();
        a = 5'($urandom_range(31));
        d = 8'($urandom_range(255));
        wr(a, d);
        shadow[a] = d;
`ifdef LCD_AUTO_REFRESH_EN
        wait_starts(base + 34, 34 * 40, "auto");
        check_refresh(base, "auto");
`else
        tick(200);
        checks++;
        if (got_d.size() !== base) begin
            errors++;
            $display("FAIL auto off: got %0d transfers want 0", got_d.size() - base);
        end
`endif
    endtask

    initial begin
        init_seq = '{8'h38, 8'h0C, 8'h06, 8'h01};
        test_reset();
        test_init();
        test_hello();
        test_random_fill();
        test_back_to_back();
        test_mid_write();
        test_reset_mid();
        test_auto_refresh();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
